// File: rtl/ddram_arb.sv
// Two-port round-robin arbiter and burst sequencer for the shared 64-bit DDRAM Avalon-MM port.
// Port A is read-only, port B reads or writes; one transaction is outstanding at a time.
module ddram_arb #(
    parameter int unsigned AW       = 29,
    parameter int unsigned MAXBURST = 128
) (
    input  logic          clk_sys,
    input  logic          reset_n,

    input  logic          a_req,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_burst,
    output logic          a_ack,
    output logic [63:0]   a_dout,
    output logic          a_dout_ready,

    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_burst,
    input  logic [63:0]   b_din,
    input  logic [7:0]    b_be,
    output logic          b_ack,
    output logic          b_wr_next,
    output logic [63:0]   b_dout,
    output logic          b_dout_ready,

    input  logic          DDRAM_BUSY,
    input  logic [63:0]   DDRAM_DOUT,
    input  logic          DDRAM_DOUT_READY,
    output logic          DDRAM_CLK,
    output logic [7:0]    DDRAM_BURSTCNT,
    output logic [AW-1:0] DDRAM_ADDR,
    output logic          DDRAM_RD,
    output logic [63:0]   DDRAM_DIN,
    output logic [7:0]    DDRAM_BE,
    output logic          DDRAM_WE
);

    typedef enum logic [1:0] {StIdle, StRdCmd, StRdData, StWrBurst} state_e;

    state_e        state_q;
    logic          owner_q;  // 1 = port B
    logic          last_q;   // 1 = port B was granted last
    logic          first_q;  // next accepted write beat is the first of the burst
    logic [AW-1:0] addr_q;
    logic [7:0]    burst_q;
    logic [7:0]    beats_q;
    logic          rd_q;
    logic          we_q;
    logic          a_ack_q;
    logic          b_ack_q;
    logic          wr_next_q;

    logic          grant_b;
    logic [7:0]    req_cnt;

    function automatic logic [7:0] clamp_cnt(input logic [7:0] n);
        if (n == 8'd0) begin
            return 8'd1;
        end
        if (32'(n) > MAXBURST) begin
            return 8'(MAXBURST);
        end
        return n;
    endfunction

    // On a tie the port that was not granted last wins.
    always_comb begin
        grant_b = b_req & (~a_req | ~last_q);
        req_cnt = clamp_cnt(grant_b ? b_burst : a_burst);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            last_q    <= 1'b1;
            first_q   <= 1'b0;
            addr_q    <= '0;
            burst_q   <= '0;
            beats_q   <= '0;
            rd_q      <= 1'b0;
            we_q      <= 1'b0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            wr_next_q <= 1'b0;
        end else begin
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            wr_next_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (a_req || b_req) begin
                        owner_q <= grant_b;
                        last_q  <= grant_b;
                        first_q <= 1'b1;
                        addr_q  <= grant_b ? b_addr : a_addr;
                        burst_q <= req_cnt;
                        beats_q <= req_cnt;
                        if (grant_b && b_we) begin
                            we_q    <= 1'b1;
                            state_q <= StWrBurst;
                        end else begin
                            rd_q    <= 1'b1;
                            state_q <= StRdCmd;
                        end
                    end
                end
                StRdCmd: begin
                    if (!DDRAM_BUSY) begin
                        rd_q    <= 1'b0;
                        a_ack_q <= ~owner_q;
                        b_ack_q <= owner_q;
                        state_q <= StRdData;
                    end
                end
                StRdData: begin
                    if (DDRAM_DOUT_READY) begin
                        beats_q <= beats_q - 8'd1;
                        if (beats_q == 8'd1) begin
                            state_q <= StIdle;
                        end
                    end
                end
                StWrBurst: begin
                    if (!DDRAM_BUSY) begin
                        wr_next_q <= 1'b1;
                        b_ack_q   <= first_q;
                        first_q   <= 1'b0;
                        beats_q   <= beats_q - 8'd1;
                        if (beats_q == 8'd1) begin
                            we_q    <= 1'b0;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read beats are only routed while a read is in flight; stale beats are dropped.
    always_comb begin
        a_dout_ready = DDRAM_DOUT_READY & (state_q == StRdData) & ~owner_q;
        b_dout_ready = DDRAM_DOUT_READY & (state_q == StRdData) & owner_q;
    end

    assign a_dout         = DDRAM_DOUT;
    assign b_dout         = DDRAM_DOUT;
    assign a_ack          = a_ack_q;
    assign b_ack          = b_ack_q;
    assign b_wr_next      = wr_next_q;
    assign DDRAM_CLK      = clk_sys;
    assign DDRAM_BURSTCNT = burst_q;
    assign DDRAM_ADDR     = addr_q;
    assign DDRAM_RD       = rd_q;
    assign DDRAM_WE       = we_q;
    assign DDRAM_DIN      = b_din;
    assign DDRAM_BE       = b_be;

endmodule

// File: doc/ddram_arb.md
# ddram_arb

Two-port arbiter and sequencer for the shared 64-bit DDRAM Avalon-MM interface of `emu`. It grants the port to one requester at a time using round-robin order. It issues the command and tracks burst beats until the transaction completes. Port A is a read-only client, e.g. a framebuffer or video fetch. Port B is a read/write client, e.g. the core or the HPS loader. The block sits between core logic and the `DDRAM_*` top-level ports. Only one transaction is outstanding at a time.

## Interface
Parameters:
- `AW`, 29: word address width; matches `DDRAM_ADDR`.
- `MAXBURST`, 128: largest legal burst. A larger requested count is clamped to `MAXBURST`.

Ports:
- `clk_sys` in 1: single clock. Also drives `DDRAM_CLK`.
- `reset_n` in 1: reset, asynchronous, active-low.
- `a_req` in 1: port A read request. `a_addr` and `a_burst` are held stable until `a_ack`.
- `a_addr` in AW: port A start address.
- `a_burst` in 8: port A beat count. A value of 0 is treated as 1.
- `a_ack` out 1: one-cycle pulse when port A's command is accepted by DDRAM.
- `a_dout` out 64: read data (alias of `DDRAM_DOUT`).
- `a_dout_ready` out 1: valid read beat for port A.
- `b_req` in 1: port B request. `b_we`, `b_addr`, `b_burst` and `b_be` are held until `b_ack`.
- `b_we` in 1: 1 = write, 0 = read.
- `b_addr` in AW: port B start address.
- `b_burst` in 8: port B beat count. A value of 0 is treated as 1.
- `b_din` in 64: current write beat data.
- `b_be` in 8: write byte enables.
- `b_ack` out 1: one-cycle pulse when port B's command (first beat, for writes) is accepted.
- `b_wr_next` out 1: pulse per accepted write beat. Port B presents the next beat on the following cycle.
- `b_dout` out 64, `b_dout_ready` out 1: same as port A.
- `DDRAM_BUSY` in 1, `DDRAM_DOUT` in 64, `DDRAM_DOUT_READY` in 1: from the top level.
- `DDRAM_CLK` out 1, `DDRAM_BURSTCNT` out 8, `DDRAM_ADDR` out 29, `DDRAM_RD` out 1, `DDRAM_DIN` out 64, `DDRAM_BE` out 8, `DDRAM_WE` out 1: to the top level.

## Operation
- States: `IDLE`, `RD_CMD`, `RD_DATA`, `WR_BURST`.
- `IDLE`:
  - If only one request is pending, grant it.
  - If both are pending, grant the port that was not the last grant. `last` resets to B, so A wins the first tie.
  - On grant, register `owner`, `last`, `DDRAM_ADDR`, `DDRAM_BURSTCNT` (clamped, 0→1) and `beats` (= clamped count).
  - Grant of A, or of B with `b_we`=0, goes to `RD_CMD`. Grant of B with `b_we`=1 goes to `WR_BURST`.
- `RD_CMD`:
  - `DDRAM_RD`=1.
  - On an edge with `DDRAM_BUSY`=0: pulse the owner's ack, drop `DDRAM_RD`, go to `RD_DATA`.
- `RD_DATA`:
  - Each `DDRAM_DOUT_READY` beat decrements `beats` and is routed to the owner's `*_dout_ready`.
  - On the last beat (`beats`==1), go to `IDLE`.
- `WR_BURST`:
  - `DDRAM_WE`=1. `DDRAM_DIN`/`DDRAM_BE` follow `b_din`/`b_be` combinationally.
  - A beat is accepted on any edge with `DDRAM_BUSY`=0: pulse `b_wr_next`, decrement `beats`.
  - The first accepted beat also pulses `b_ack`.
  - On the last beat, drop `DDRAM_WE` and go to `IDLE`.
- While `DDRAM_RD` or `DDRAM_WE` is high and `DDRAM_BUSY`=1, `DDRAM_ADDR`, `DDRAM_BURSTCNT` and the read/write strobe hold stable.
- `DDRAM_DOUT_READY` beats outside `RD_DATA` (e.g. stale beats after reset) are discarded: both `*_dout_ready` stay 0.
- Requests arriving during a transaction wait. A request dropped before ack is ignored only if it is still in `IDLE`; once granted, the command completes.

## Timing
- Reset, asynchronous, `reset_n`=0:
  - State is `IDLE`, `last`=B.
  - All outputs are 0: `DDRAM_RD`, `DDRAM_WE`, `DDRAM_ADDR`, `DDRAM_BURSTCNT`, acks, `b_wr_next`, `*_dout_ready`.
  - `DDRAM_DIN`, `DDRAM_BE`, `a_dout` and `b_dout` are data paths with no reset value.
- Reset mid-burst aborts immediately. Requesters must reissue.
- Grant latency: a request sampled at edge N gives `DDRAM_RD`/`DDRAM_WE` high after edge N. The earliest ack comes at edge N+1.
- Read turnaround: after the last beat, `IDLE` is entered. The next command strobe comes no earlier than 1 cycle later, so there is 1 idle cycle between transactions.
- `*_dout_ready` is combinational from `DDRAM_DOUT_READY` and `owner`, with zero latency.
- Write: one beat per cycle when `BUSY`=0. Port B must update `b_din` in the cycle after `b_wr_next`.
- All outputs are registered, except `DDRAM_DIN`/`DDRAM_BE`, `*_dout` and `*_dout_ready`.

## Test plan
- A single read of `a_addr`=0x100, `a_burst`=4, with `BUSY`=0 and 4 `DOUT_READY` beats (data 1..4):
  - `a_ack` pulses once.
  - `a_dout_ready` pulses 4×.
  - The FSM is back in `IDLE` 1 cycle after beat 4.
  - `b_dout_ready` stays 0.
- A and B read requests asserted in the same cycle, both kept asserted:
  - Grant order is A, B, A, B.
  - `DDRAM_ADDR` alternates between `a_addr` and `b_addr`.
- B write burst of 3 with `BUSY` high for 2 cycles on beat 2:
  - `DDRAM_WE` stays high for 5 cycles.
  - `b_wr_next` pulses 3×.
  - `DDRAM_DIN` matches `b_din` at each accepted beat.
- `BUSY`=1 for 10 cycles during `RD_CMD`:
  - `DDRAM_RD`, `DDRAM_ADDR` and `DDRAM_BURSTCNT` are stable throughout.
  - The ack fires on the first `BUSY`=0 edge.
- `a_burst`=0:
  - `DDRAM_BURSTCNT`=1 and a single beat completes.
  - A count of 200 with `MAXBURST`=128 is clamped to 128.
- `reset_n` pulsed low mid-read (beat 2 of 4), then 2 stale `DOUT_READY` beats:
  - All strobes go to 0 asynchronously.
  - Both `*_dout_ready` stay 0.
  - The next A request is granted normally.
